main_memory_refill: RTL and testbench
=====================================

// Module: main_memory_refill
// PURPOSE
// Backing word-addressed main memory on the far side of the cache refill interface. On a line
// fill request it waits a fixed access latency, then streams the 4 words of the line as
// write_from_memory/data_in_memory beats. Beats are critical-word-first and carry the word
// address the cache must write. It also accepts single-word write-through stores from the
// cache controller.
// PARAMETERS
// ADDR_WIDTH      10    word address width; line index = addr[9:2], offset = addr[1:0]
// DATA_WIDTH      32    word width
// LINE_WORDS      4     words per line (power of 2; offset width = log2)
// MEM_DEPTH       1024  words of storage (= 2**ADDR_WIDTH)
// READ_LATENCY    4     idle cycles between fill acceptance and first beat (0..15)
// PORTS
// clk                 in   1           clock, all logic on rising edge
// rst                 in   1           synchronous, active-low reset
// fill_req            in   1           line fill request, held by requester until fill_busy=1
// fill_addr           in   ADDR_WIDTH  missing word address (critical word)
// fill_busy           out  1           fill in progress (WAIT or BURST)
// write_from_memory   out  1           beat valid: cache writes data_in_memory at fill_word_addr
// fill_word_addr      out  ADDR_WIDTH  word address of current beat
// data_in_memory      out  DATA_WIDTH  beat data
// fill_done           out  1           1-cycle pulse coincident with the last beat
// wr_req              in   1           write-through store request, held until wr_ack
// wr_addr             in   ADDR_WIDTH  store word address
// wr_data             in   DATA_WIDTH  store data
// wr_ack              out  1           1-cycle pulse, store committed at this edge
// BEHAVIOUR
// - All outputs registered. Reset (rst=0 at an edge): state=IDLE, counters=0, every output=0;
//   aborts any fill/store in flight mid-operation; memory array contents are NOT cleared.
// - FSM states: IDLE, WAIT, BURST.
// - IDLE: wr_req=1 -> mem[wr_addr]<=wr_data, wr_ack=1 next cycle, stay IDLE (one store per
//   cycle; wr_ack forced 0 the cycle after an ack so a held wr_req is not double-committed).
//   Else fill_req=1 -> latch line=fill_addr[9:2], start=fill_addr[1:0], beat=0; go WAIT
//   (or BURST if READ_LATENCY=0).
// - Simultaneous wr_req and fill_req in IDLE: store wins; fill accepted on a later IDLE cycle,
//   so a refill always returns data including that store.
// - WAIT: count READ_LATENCY cycles, then BURST. fill_req/wr_req ignored (wr_ack stays 0).
// - BURST: LINE_WORDS consecutive cycles, write_from_memory=1.
//   fill_word_addr={line, (start+beat) mod LINE_WORDS} (offset wraps within line, never
//   crosses line); data_in_memory=mem[fill_word_addr].
// - Last beat: fill_done=1; next cycle IDLE, fill_busy=0.
// - Timing: fill accepted at edge T -> fill_busy=1 from T+1; beats at
//   T+1+READ_LATENCY .. T+READ_LATENCY+LINE_WORDS. fill_busy drops after last beat.
// - Requester must deassert fill_req once fill_busy=1; a fill_req still high in IDLE starts a
//   new fill.
// - Stores are blocked during a fill; no store/fill overlap exists, so no hazard logic needed.
// TESTING
// 1 Reset: drive rst=0 mid-BURST -> next edge all outputs 0, state IDLE; memory data retained.
// 2 Store 0xDEADBEEF@0x010 -> wr_ack 1 cycle later. Fill addr 0x010, LAT=4 -> beats at
//   T+5..T+8, addrs 0x010,011,012,013, first data 0xDEADBEEF, fill_done on 0x013.
// 3 Critical-word wrap: mem[0x3FC..0x3FF]=1,2,3,4; fill 0x3FE -> addrs 0x3FE,3FF,3FC,3FD,
//   data 3,4,1,2.
// 4 Simultaneous wr_req(0x021,0xA5A5A5A5)+fill_req(0x020) -> wr_ack first; fill returns
//   0xA5A5A5A5 at 0x021.
// 5 wr_req raised during WAIT -> wr_ack stays 0 until IDLE, then commits exactly once.
// 6 READ_LATENCY=0 build: fill at T -> beats T+1..T+4; back-to-back fills, no gap beyond 1 IDLE.

Source files
------------

// File: rtl/main_memory_refill.sv
// Word-addressed backing memory behind the cache refill port: streams a line critical-word-first
// after a fixed access latency and accepts single-word write-through stores while idle.
module main_memory_refill #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int LINE_WORDS   = 4,
    parameter int MEM_DEPTH    = 1024,
    parameter int READ_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_req,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    output logic                  fill_busy,
    output logic                  write_from_memory,
    output logic [ADDR_WIDTH-1:0] fill_word_addr,
    output logic [DATA_WIDTH-1:0] data_in_memory,
    output logic                  fill_done,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int LINE_W = ADDR_WIDTH - OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             wait_cnt;
    logic [OFF_W-1:0]       beat;
    logic [OFF_W-1:0]       start;
    logic [LINE_W-1:0]      line;

    logic                   store_go;
    logic                   fill_go;
    logic [LINE_W-1:0]      sel_line;
    logic [OFF_W-1:0]       sel_start;
    logic [OFF_W-1:0]       sel_beat;
    logic [OFF_W-1:0]       sel_off;
    logic [ADDR_WIDTH-1:0]  beat_addr;
    logic                   busy_nxt;
    logic                   wfm_nxt;
    logic                   done_nxt;
    logic                   ack_nxt;

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    // A store blocks itself for one cycle after its ack so a still-held wr_req is not re-committed.
    assign store_go = (state == S_IDLE) && wr_req && !wr_ack;
    assign fill_go  = (state == S_IDLE) && !store_go && fill_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fill_go) state_nxt = (READ_LATENCY == 0) ? S_BURST : S_WAIT;
            S_WAIT:  if (wait_cnt == 4'(READ_LATENCY - 1)) state_nxt = S_BURST;
            S_BURST: if (fill_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next-cycle output values; a fill being accepted this edge supplies its own line/start.
    always_comb begin
        sel_line  = fill_go ? fill_addr[ADDR_WIDTH-1:OFF_W] : line;
        sel_start = fill_go ? fill_addr[OFF_W-1:0] : start;
        sel_beat  = fill_go ? '0 : beat;
        sel_off   = sel_start + sel_beat;
        beat_addr = {sel_line, sel_off};
        busy_nxt  = (state_nxt != S_IDLE);
        wfm_nxt   = (state_nxt == S_BURST);
        done_nxt  = wfm_nxt && (sel_beat == OFF_W'(LINE_WORDS - 1));
        ack_nxt   = store_go;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt          <= '0;
            beat              <= '0;
            start             <= '0;
            line              <= '0;
            fill_busy         <= 1'b0;
            write_from_memory <= 1'b0;
            fill_word_addr    <= '0;
            data_in_memory    <= '0;
            fill_done         <= 1'b0;
            wr_ack            <= 1'b0;
        end else begin
            if (fill_go) begin
                line  <= fill_addr[ADDR_WIDTH-1:OFF_W];
                start <= fill_addr[OFF_W-1:0];
            end
            if (state_nxt == S_WAIT && state == S_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end
            beat              <= wfm_nxt ? (sel_beat + OFF_W'(1)) : '0;
            fill_busy         <= busy_nxt;
            write_from_memory <= wfm_nxt;
            fill_done         <= done_nxt;
            wr_ack            <= ack_nxt;
            fill_word_addr    <= wfm_nxt ? beat_addr : '0;
            data_in_memory    <= wfm_nxt ? mem[beat_addr] : '0;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clk) begin
        if (rst && store_go) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_main_memory_refill.sv
// Scoreboard bench for main_memory_refill: one instance with latency 4 and one with latency 0,
// expected beats/acks queued at stimulus time and matched by a negedge monitor.
module tb_main_memory_refill;

    typedef struct {
        int          inst;
        int          cyc;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        done;
    } beat_t;

    typedef struct {
        int inst;
        int cyc;
    } ack_t;

    logic clk;
    logic rst;

    logic        a_fill_req, a_fill_busy, a_wfm, a_fill_done, a_wr_req, a_wr_ack;
    logic [9:0]  a_fill_addr, a_word_addr, a_wr_addr;
    logic [31:0] a_data, a_wr_data;

    logic        z_fill_req, z_fill_busy, z_wfm, z_fill_done, z_wr_req, z_wr_ack;
    logic [9:0]  z_fill_addr, z_word_addr, z_wr_addr;
    logic [31:0] z_data, z_wr_data;

    beat_t       beat_q[$];
    ack_t        ack_q[$];
    logic [31:0] model [2][1024];
    int          cyc;
    int          total;
    int          bad;
    bit          mon_en;

    main_memory_refill #(.READ_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst),
        .fill_req(a_fill_req), .fill_addr(a_fill_addr), .fill_busy(a_fill_busy),
        .write_from_memory(a_wfm), .fill_word_addr(a_word_addr), .data_in_memory(a_data),
        .fill_done(a_fill_done), .wr_req(a_wr_req), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .wr_ack(a_wr_ack)
    );

    main_memory_refill #(.READ_LATENCY(0)) dutz (
        .clk(clk), .rst(rst),
        .fill_req(z_fill_req), .fill_addr(z_fill_addr), .fill_busy(z_fill_busy),
        .write_from_memory(z_wfm), .fill_word_addr(z_word_addr), .data_in_memory(z_data),
        .fill_done(z_fill_done), .wr_req(z_wr_req), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
        .wr_ack(z_wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s (cyc %0d)", name, cyc);
    endtask

    // Monitor side: every beat or ack the DUT presents must match the head of its queue.
    task automatic check_output(input int inst, input logic wfm, input logic [9:0] addr,
                                input logic [31:0] data, input logic done, input logic ack);
        beat_t b;
        ack_t  a;
        if (wfm) begin
            if (beat_q.size() == 0) begin
                flag_fail($sformatf("stray_beat inst%0d addr=%0h", inst, addr));
            end else begin
                b = beat_q.pop_front();
                check_val($sformatf("beat_inst a%0h", b.addr), 64'(inst), 64'(b.inst));
                check_val($sformatf("beat_cycle a%0h", b.addr), 64'(cyc), 64'(b.cyc));
                check_val("beat_addr", 64'(addr), 64'(b.addr));
                check_val($sformatf("beat_data a%0h", b.addr), 64'(data), 64'(b.data));
                check_val($sformatf("beat_done a%0h", b.addr), 64'(done), 64'(b.done));
            end
        end else if (done) begin
            flag_fail($sformatf("done_without_beat inst%0d", inst));
        end
        if (ack) begin
            if (ack_q.size() == 0) begin
                flag_fail($sformatf("stray_wr_ack inst%0d", inst));
            end else begin
                a = ack_q.pop_front();
                check_val("ack_inst", 64'(inst), 64'(a.inst));
                check_val("ack_cycle", 64'(cyc), 64'(a.cyc));
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_output(0, a_wfm, a_word_addr, a_data, a_fill_done, a_wr_ack);
            check_output(1, z_wfm, z_word_addr, z_data, z_fill_done, z_wr_ack);
        end
    end

    function automatic logic sig_of(input int inst, input int which);
        case (which)
            0:       return (inst == 0) ? a_fill_busy : z_fill_busy;
            1:       return (inst == 0) ? a_wfm : z_wfm;
            default: return (inst == 0) ? a_wr_ack : z_wr_ack;
        endcase
    endfunction

    task automatic wait_level(input string name, input int inst, input int which,
                              input logic lvl, input int limit);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(posedge clk);
            #1;
            if (sig_of(inst, which) == lvl) hit = 1'b1;
        end
        if (!hit) flag_fail($sformatf("timeout_%s inst%0d", name, inst));
    endtask

    task automatic push_fill(input int inst, input logic [9:0] addr, input int p);
        int lat;
        lat = (inst == 0) ? 4 : 0;
        for (int k = 0; k < 4; k++) begin
            beat_t      e;
            logic [1:0] off;
            off    = addr[1:0] + 2'(k);
            e.inst = inst;
            e.cyc  = p + lat + k;
            e.addr = {addr[9:2], off};
            e.data = model[inst][e.addr];
            e.done = (k == 3);
            beat_q.push_back(e);
        end
    endtask

    task automatic push_ack(input int inst, input int c);
        ack_t a;
        a.inst = inst;
        a.cyc  = c;
        ack_q.push_back(a);
    endtask

    // Called #1 after an edge with the addressed instance idle.
    task automatic apply_stimulus(input int inst, input bit is_fill,
                                  input logic [9:0] addr, input logic [31:0] data);
        if (is_fill) begin
            push_fill(inst, addr, cyc + 1);
            if (inst == 0) begin a_fill_req = 1'b1; a_fill_addr = addr; end
            else           begin z_fill_req = 1'b1; z_fill_addr = addr; end
            wait_level("busy_rise", inst, 0, 1'b1, 8);
            if (inst == 0) a_fill_req = 1'b0; else z_fill_req = 1'b0;
            wait_level("busy_fall", inst, 0, 1'b0, 40);
        end else begin
            push_ack(inst, cyc + 1);
            model[inst][addr] = data;
            if (inst == 0) begin a_wr_req = 1'b1; a_wr_addr = addr; a_wr_data = data; end
            else           begin z_wr_req = 1'b1; z_wr_addr = addr; z_wr_data = data; end
            wait_level("wr_ack", inst, 2, 1'b1, 8);
            @(posedge clk);
            #1;
            if (inst == 0) a_wr_req = 1'b0; else z_wr_req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int p;
        total = 0;
        bad = 0;
        cyc = 0;
        mon_en = 1'b0;
        rst = 1'b0;
        a_fill_req = 0; a_fill_addr = '0; a_wr_req = 0; a_wr_addr = '0; a_wr_data = '0;
        z_fill_req = 0; z_fill_addr = '0; z_wr_req = 0; z_wr_addr = '0; z_wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_busy", 64'(a_fill_busy), 0);
        check_val("reset_wfm", 64'(a_wfm), 0);
        check_val("reset_addr", 64'(a_word_addr), 0);
        check_val("reset_data", 64'(a_data), 0);
        check_val("reset_done", 64'(a_fill_done), 0);
        check_val("reset_ack", 64'(a_wr_ack), 0);
        check_val("reset_z_busy", 64'(z_fill_busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;

        // Basic store then in-order fill from the critical word.
        apply_stimulus(0, 0, 10'h010, 32'hDEADBEEF);
        apply_stimulus(0, 0, 10'h011, 32'h11111111);
        apply_stimulus(0, 0, 10'h012, 32'h22222222);
        apply_stimulus(0, 0, 10'h013, 32'h33333333);
        apply_stimulus(0, 1, 10'h010, '0);

        // Offset wraps inside the line.
        apply_stimulus(0, 0, 10'h3FC, 32'd1);
        apply_stimulus(0, 0, 10'h3FD, 32'd2);
        apply_stimulus(0, 0, 10'h3FE, 32'd3);
        apply_stimulus(0, 0, 10'h3FF, 32'd4);
        apply_stimulus(0, 1, 10'h3FE, '0);

        // Store and fill together: store commits first, fill sees it.
        apply_stimulus(0, 0, 10'h020, 32'h20202020);
        apply_stimulus(0, 0, 10'h022, 32'h22220000);
        apply_stimulus(0, 0, 10'h023, 32'h23230000);
        push_ack(0, cyc + 1);
        model[0][10'h021] = 32'hA5A5A5A5;
        push_fill(0, 10'h020, cyc + 2);
        a_wr_req = 1'b1; a_wr_addr = 10'h021; a_wr_data = 32'hA5A5A5A5;
        a_fill_req = 1'b1; a_fill_addr = 10'h020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_wr_req = 1'b0;
        a_fill_req = 1'b0;
        wait_level("busy_fall", 0, 0, 1'b0, 40);

        // Store raised while a fill is waiting is held off until the fill finishes.
        apply_stimulus(0, 0, 10'h030, 32'h30303030);
        apply_stimulus(0, 0, 10'h031, 32'h31000000);
        apply_stimulus(0, 0, 10'h032, 32'h32323232);
        apply_stimulus(0, 0, 10'h033, 32'h33330000);
        p = cyc + 1;
        push_fill(0, 10'h030, p);
        a_fill_req = 1'b1; a_fill_addr = 10'h030;
        @(posedge clk); #1;
        a_fill_req = 1'b0;
        @(posedge clk); #1;
        push_ack(0, p + 4 + 4 + 1);
        model[0][10'h031] = 32'h31313131;
        a_wr_req = 1'b1; a_wr_addr = 10'h031; a_wr_data = 32'h31313131;
        wait_level("deferred_ack", 0, 2, 1'b1, 20);
        @(posedge clk); #1;
        a_wr_req = 1'b0;
        apply_stimulus(0, 1, 10'h032, '0);

        // Reset in the middle of a burst; memory must survive.
        apply_stimulus(0, 0, 10'h040, 32'h40404040);
        apply_stimulus(0, 0, 10'h041, 32'h41414141);
        apply_stimulus(0, 0, 10'h042, 32'h42424242);
        apply_stimulus(0, 0, 10'h043, 32'h43434343);
        mon_en = 1'b0;
        a_fill_req = 1'b1; a_fill_addr = 10'h040;
        wait_level("busy_rise", 0, 0, 1'b1, 8);
        a_fill_req = 1'b0;
        wait_level("burst_start", 0, 1, 1'b1, 10);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("midreset_busy", 64'(a_fill_busy), 0);
        check_val("midreset_wfm", 64'(a_wfm), 0);
        check_val("midreset_addr", 64'(a_word_addr), 0);
        check_val("midreset_data", 64'(a_data), 0);
        check_val("midreset_done", 64'(a_fill_done), 0);
        check_val("midreset_ack", 64'(a_wr_ack), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;
        apply_stimulus(0, 1, 10'h041, '0);

        // Zero-latency instance: held fill_req gives back-to-back fills with one idle cycle.
        apply_stimulus(1, 0, 10'h100, 32'h10000000);
        apply_stimulus(1, 0, 10'h101, 32'h10100000);
        apply_stimulus(1, 0, 10'h102, 32'h10200000);
        apply_stimulus(1, 0, 10'h103, 32'h10300000);
        p = cyc + 1;
        push_fill(1, 10'h102, p);
        push_fill(1, 10'h101, p + 5);
        z_fill_req = 1'b1; z_fill_addr = 10'h102;
        @(posedge clk); #1;
        z_fill_addr = 10'h101;
        repeat (5) begin
            @(posedge clk); #1;
        end
        z_fill_req = 1'b0;
        wait_level("busy_fall", 1, 0, 1'b0, 40);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("beat_queue_drained", 64'(beat_q.size()), 0);
        check_val("ack_queue_drained", 64'(ack_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
